// File: rtl/debug_capture_arbiter_pkg.sv
// Shared constants and types for the debug capture arbiter.
package debug_capture_pkg;

    localparam int NUM_SRC_DEF    = 4;
    localparam int ID_W_DEF       = 2;
    localparam int DROP_CNT_W_DEF = 8;
    localparam int TS_W           = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/debug_capture_arbiter_if.sv
// Debug output channel: valid/ready byte handshake tagged with source ID.
// Carries out_timestamp only when DEBUG_CAPTURE_TIMESTAMP_EN is defined.
interface debug_capture_arbiter_if
    import debug_capture_pkg::*;
#(
    parameter int ID_W = ID_W_DEF
);
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [ID_W-1:0] out_src;
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] out_timestamp;

    modport master (output out_valid, output out_data, output out_src,
                    output out_timestamp, input out_ready);
    modport slave  (input out_valid, input out_data, input out_src,
                    input out_timestamp, output out_ready);
`else
    modport master (output out_valid, output out_data, output out_src,
                    input out_ready);
    modport slave  (input out_valid, input out_data, input out_src,
                    output out_ready);
`endif
endinterface

// File: rtl/debug_capture_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending index at or after ptr, wrapping.
module debug_rr_picker
    import debug_capture_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = ID_W_DEF
)(
    input  logic [NUM_SRC-1:0] pending,
    input  logic [ID_W-1:0]    ptr,
    output logic               any_req,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W:0] idx;

    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_SRC)) begin
                idx = idx - (ID_W+1)'(NUM_SRC);
            end
            if (!any_req && pending[idx[ID_W-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/debug_capture_arbiter.sv
// Per-source one-entry capture registers feeding a round-robin debug output channel.
// Optional per-capture cycle stamps when DEBUG_CAPTURE_TIMESTAMP_EN is defined.
//
//   state | meaning
//   IDLE  | no byte offered; grants the next pending source when enabled
//   SEND  | out_valid=1, byte held stable until out_ready
module debug_capture_arbiter
    import debug_capture_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int ID_W       = ID_W_DEF,
    parameter int DROP_CNT_W = DROP_CNT_W_DEF
)(
    input  logic                           clock_50,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_SRC-1:0]             src_strobe,
    input  logic [8*NUM_SRC-1:0]           src_data,
    debug_capture_arbiter_if.master        out_if,
    output logic                           busy,
    output logic [NUM_SRC*DROP_CNT_W-1:0]  drop_count
);

    arb_state_t            state_q;
    arb_state_t            state_nxt;
    logic                  grant;
    logic                  done;

    logic [NUM_SRC-1:0]    pending_q;
    logic [7:0]            hold_q [NUM_SRC];
    logic [DROP_CNT_W-1:0] drop_q [NUM_SRC];
    logic [NUM_SRC-1:0]    done_vec;
    logic [NUM_SRC-1:0]    cap_vec;
    logic [NUM_SRC-1:0]    drop_vec;

    logic [ID_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]       win_idx;
    logic                  any_req;
    logic [7:0]            data_q;
    logic [ID_W-1:0]       src_q;

    debug_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_picker (
        .pending (pending_q),
        .ptr     (rr_ptr_q),
        .any_req (any_req),
        .winner  (win_idx)
    );

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        grant     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && any_req) begin
                    grant     = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_if.out_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A strobe landing on the cycle its own byte leaves refills the slot instead of dropping.
    always_comb begin
        done_vec = '0;
        cap_vec  = '0;
        drop_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            done_vec[i] = done && (src_q == ID_W'(i));
            cap_vec[i]  = src_strobe[i] && (!pending_q[i] || done_vec[i]);
            drop_vec[i] = src_strobe[i] && pending_q[i] && !done_vec[i];
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            pending_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_q[i] <= '0;
                drop_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cap_vec[i]) begin
                    hold_q[i]    <= src_data[8*i +: 8];
                    pending_q[i] <= 1'b1;
                end else if (done_vec[i]) begin
                    pending_q[i] <= 1'b0;
                end
                if (drop_vec[i] && (drop_q[i] != '1)) begin
                    drop_q[i] <= drop_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            data_q   <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (grant) begin
                data_q <= hold_q[win_idx];
                src_q  <= win_idx;
            end
            if (done) begin
                rr_ptr_q <= (src_q == ID_W'(NUM_SRC-1)) ? '0 : src_q + 1'b1;
            end
        end
    end

`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] stamp_q [NUM_SRC];
    logic [TS_W-1:0] ts_out_q;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            ts_out_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cap_vec[i]) begin
                    stamp_q[i] <= ts_cnt_q;
                end
            end
            if (grant) begin
                ts_out_q <= stamp_q[win_idx];
            end
        end
    end

    assign out_if.out_timestamp = ts_out_q;
`endif

    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_data  = data_q;
    assign out_if.out_src   = src_q;
    assign busy             = (|pending_q) || (state_q == SEND);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_drop
        assign drop_count[g*DROP_CNT_W +: DROP_CNT_W] = drop_q[g];
    end

endmodule
